cruise_ctrl_gen2: RTL and testbench
===================================

CRUISE_CTRL_GEN2 -- requirements
Module: cruise_ctrl_gen2

Interface
REQ-001 Parameter SPEED_W, default 8: width of speed and cruisespeed.
REQ-002 Parameter MIN_ENGAGE, default 46: minimum speed for set and resume.
REQ-003 Parameter MAX_SPEED, default 200: saturation ceiling, SHALL satisfy MIN_ENGAGE <= MAX_SPEED <= 2^SPEED_W-1.
REQ-004 Parameters ACC_STEP (default 1), BRK_STEP (default 2), COAST_STEP (default 1), RAMP_STEP (default 1): per-cycle speed deltas.
REQ-005 Parameter HOLD_CYC, default 4: accel/coast auto-repeat interval in cycles, >= 1.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 throttle, set, accel, coast, cancel, resume, brake  input  1 each  driver controls, sampled every clock edge.
REQ-009 speed  output  SPEED_W  current vehicle speed, registered.
REQ-010 cruisespeed  output  SPEED_W  cruise target, registered.
REQ-011 cruisectrl  output  1  high while cruise is engaged (CRUISE state).
REQ-012 state_o  output  3  current FSM state code.

Function
REQ-013 States SHALL be IDLE, ACCEL, DECEL, CRUISE, BRAKE, CANCEL; unused codes go to IDLE with outputs unchanged.
REQ-014 All speed/cruisespeed arithmetic SHALL saturate: additions clamp at MAX_SPEED, subtractions clamp at 0; no wrap-around.
REQ-015 IDLE: throttle=1 -> ACCEL, speed += ACC_STEP; else stay, speed unchanged.
REQ-016 ACCEL: set=1, throttle=1, speed >= MIN_ENGAGE -> CRUISE, cruisespeed <= pre-increment speed, speed += ACC_STEP, cruisectrl=1.
REQ-017 ACCEL: otherwise throttle=0 -> DECEL, speed -= COAST_STEP; throttle=1 -> stay, speed += ACC_STEP.
REQ-018 DECEL: throttle=1 -> ACCEL, speed += ACC_STEP; throttle=0 and speed > 0 -> speed -= COAST_STEP; throttle=0 and speed = 0 -> IDLE.
REQ-019 CRUISE priority SHALL be brake > cancel > accel > coast > throttle > regulate.
REQ-020 CRUISE brake -> BRAKE, speed -= BRK_STEP, cruisectrl=0; cruisespeed retained.
REQ-021 CRUISE cancel -> CANCEL, speed -= COAST_STEP, cruisectrl=0; cruisespeed retained.
REQ-022 CRUISE accel: first asserted cycle cruisespeed += ACC_STEP (clamp MAX_SPEED), then again every HOLD_CYC cycles while held; speed += ACC_STEP each cycle, clamped to cruisespeed.
REQ-023 CRUISE coast: mirror of REQ-022 with -= COAST_STEP; cruisespeed clamps at MIN_ENGAGE; speed -= COAST_STEP each cycle, floored at cruisespeed.
REQ-024 Hold counter SHALL clear whenever accel and coast are both 0 or the state is not CRUISE; switching accel<->coast restarts it.
REQ-025 CRUISE throttle (no higher-priority input): speed += ACC_STEP, cruisespeed unchanged (override).
REQ-026 CRUISE regulate: speed moves toward cruisespeed by RAMP_STEP per cycle, never overshooting; equal -> unchanged.
REQ-027 BRAKE: brake=1 -> speed -= BRK_STEP; brake=0 and resume=1 and speed >= MIN_ENGAGE -> CRUISE, cruisectrl=1; else speed -= COAST_STEP.
REQ-028 CANCEL: resume=1 and speed >= MIN_ENGAGE and brake=0 -> CRUISE, cruisectrl=1; brake=1 -> BRAKE, speed -= BRK_STEP; else speed -= COAST_STEP.
REQ-029 BRAKE or CANCEL with speed = 0 and no resume -> IDLE, cruisespeed retained.
REQ-030 Resume below MIN_ENGAGE SHALL be ignored without error.
REQ-031 cruisectrl SHALL equal (next state == CRUISE), registered with state.

Reset
REQ-032 reset=1 at a clock edge SHALL force state IDLE, speed 0, cruisespeed 0, cruisectrl 0, hold counter 0, overriding all inputs, including mid-operation.
REQ-033 First edge with reset=0 SHALL evaluate normally from IDLE.

Structure
REQ-034 State encodings and a saturating add/sub width rule SHALL live in shared package cruise_pkg.
REQ-035 The hold/auto-repeat counter SHALL be sub-module cruise_hold_timer (inputs clk, reset, clear, enable; output tick).
REQ-036 No latches; one registered FSM process plus combinational next-state logic.

Verification
REQ-037 Reset, throttle 46 cycles, set with throttle -> cruisespeed=46, speed=47, cruisectrl=1, state_o=CRUISE.
REQ-038 In CRUISE at 50, hold accel 9 cycles (HOLD_CYC=4) -> cruisespeed 51,52,53 at cycles 1,5,9; speed tracks up to 53.
REQ-039 CRUISE at 50, brake 3 cycles -> speed 44, cruisectrl=0; resume ignored (below 46); release throttle to 0 -> IDLE.
REQ-040 Throttle held from 195 -> speed saturates at 200, no wrap; DECEL from 1 with COAST_STEP=2 -> 0 then IDLE.
REQ-041 CRUISE at 60, cancel 2 cycles, resume -> CRUISE, speed ramps back to cruisespeed 60 by RAMP_STEP.
REQ-042 Reset asserted mid-BRAKE -> next edge all outputs 0, state_o=IDLE.

Source files
------------

// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise controller: state codes, hold modes and
// the saturating arithmetic used for speed and cruise-target updates.
package cruise_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEL  = 3'd1,
    ST_DECEL  = 3'd2,
    ST_CRUISE = 3'd3,
    ST_BRAKE  = 3'd4,
    ST_CANCEL = 3'd5
  } cruise_state_e;

  typedef enum logic [1:0] {
    HOLD_NONE  = 2'd0,
    HOLD_ACC   = 2'd1,
    HOLD_COAST = 2'd2
  } hold_mode_e;

  // Arithmetic is widened to CALC_W so a sum never wraps before it is clamped;
  // SPEED_W must stay well below CALC_W.
  localparam int unsigned CALC_W = 32;

  function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] step,
                                                input logic [CALC_W-1:0] ceil);
    logic [CALC_W-1:0] sum;
    sum = a + step;
    return (sum > ceil) ? ceil : sum;
  endfunction

  function automatic logic [CALC_W-1:0] sat_sub(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] step,
                                                input logic [CALC_W-1:0] floor);
    return (a < floor + step) ? floor : a - step;
  endfunction

endpackage

// File: rtl/cruise_hold_timer.sv
// Auto-repeat timer for held accel/coast: ticks on the first enabled cycle
// (or the cycle a clear restarts it) and then every HOLD_CYC cycles.
module cruise_hold_timer #(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYC - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] phase_s;

  assign phase_s = clear ? {CW{1'b0}} : cnt_r;
  assign tick    = enable && (phase_s == {CW{1'b0}});

  // Phase counter: idles at zero whenever the repeat is not running.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (!enable) begin
      cnt_r <= {CW{1'b0}};
    end else if (phase_s == LAST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= phase_s + CW'(1'b1);
    end
  end

endmodule

// File: rtl/cruise_ctrl_gen2.sv
// Cruise controller: driver-input FSM with saturating speed model, cruise
// target with auto-repeat adjust, and resume/regulate back to the target.
module cruise_ctrl_gen2
  import cruise_pkg::*;
#(
  parameter int SPEED_W    = 8,
  parameter int MIN_ENGAGE = 46,
  parameter int MAX_SPEED  = 200,
  parameter int ACC_STEP   = 1,
  parameter int BRK_STEP   = 2,
  parameter int COAST_STEP = 1,
  parameter int RAMP_STEP  = 1,
  parameter int HOLD_CYC   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               throttle,
  input  logic               set,
  input  logic               accel,
  input  logic               coast,
  input  logic               cancel,
  input  logic               resume,
  input  logic               brake,
  output logic [SPEED_W-1:0] speed,
  output logic [SPEED_W-1:0] cruisespeed,
  output logic               cruisectrl,
  output logic [2:0]         state_o
);

  localparam logic [CALC_W-1:0] K_ZERO  = {CALC_W{1'b0}};
  localparam logic [CALC_W-1:0] K_MIN   = CALC_W'(MIN_ENGAGE);
  localparam logic [CALC_W-1:0] K_MAX   = CALC_W'(MAX_SPEED);
  localparam logic [CALC_W-1:0] K_ACC   = CALC_W'(ACC_STEP);
  localparam logic [CALC_W-1:0] K_BRK   = CALC_W'(BRK_STEP);
  localparam logic [CALC_W-1:0] K_COAST = CALC_W'(COAST_STEP);
  localparam logic [CALC_W-1:0] K_RAMP  = CALC_W'(RAMP_STEP);

  cruise_state_e      state_r, state_n;
  logic [SPEED_W-1:0] speed_r, cruisespeed_r, spd_n, cs_n;
  logic               cruisectrl_r;
  hold_mode_e         mode_r, mode_s;

  logic [CALC_W-1:0]  spd_w_s, cs_w_s;
  logic [SPEED_W-1:0] spd_up_s, spd_coast_s, spd_brk_s, spd_ramp_s;
  logic [SPEED_W-1:0] cs_acc_s, cs_coast_s, spd_acc_hold_s, spd_coast_hold_s;
  logic               engage_ok_s, zero_s, tick_s, hold_en_s, hold_clr_s;

  assign speed       = speed_r;
  assign cruisespeed = cruisespeed_r;
  assign cruisectrl  = cruisectrl_r;
  assign state_o     = state_r;

  // Accel wins over coast; a change of held direction restarts the repeat.
  assign mode_s     = (state_r == ST_CRUISE && !brake && !cancel) ?
                      (accel ? HOLD_ACC : (coast ? HOLD_COAST : HOLD_NONE)) : HOLD_NONE;
  assign hold_en_s  = (mode_s != HOLD_NONE);
  assign hold_clr_s = (state_r != ST_CRUISE) || (!accel && !coast) || (mode_s != mode_r);

  cruise_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .clear  (hold_clr_s),
    .enable (hold_en_s),
    .tick   (tick_s)
  );

  assign spd_w_s     = CALC_W'(speed_r);
  assign cs_w_s      = CALC_W'(cruisespeed_r);
  assign engage_ok_s = (spd_w_s >= K_MIN);
  assign zero_s      = (speed_r == {SPEED_W{1'b0}});

  assign spd_up_s    = SPEED_W'(sat_add(spd_w_s, K_ACC, K_MAX));
  assign spd_coast_s = SPEED_W'(sat_sub(spd_w_s, K_COAST, K_ZERO));
  assign spd_brk_s   = SPEED_W'(sat_sub(spd_w_s, K_BRK, K_ZERO));
  assign cs_acc_s    = tick_s ? SPEED_W'(sat_add(cs_w_s, K_ACC, K_MAX)) : cruisespeed_r;
  assign cs_coast_s  = tick_s ? SPEED_W'(sat_sub(cs_w_s, K_COAST, K_MIN)) : cruisespeed_r;
  // While adjusting, speed follows the (possibly updated) target and is clamped to it.
  assign spd_acc_hold_s   = SPEED_W'(sat_add(spd_w_s, K_ACC, CALC_W'(cs_acc_s)));
  assign spd_coast_hold_s = SPEED_W'(sat_sub(spd_w_s, K_COAST, CALC_W'(cs_coast_s)));
  assign spd_ramp_s  = (speed_r < cruisespeed_r) ?
                       SPEED_W'(sat_add(spd_w_s, K_RAMP, cs_w_s)) :
                       SPEED_W'(sat_sub(spd_w_s, K_RAMP, cs_w_s));

  // Next-state and next-output decode.
  always_comb begin
    state_n = state_r;
    spd_n   = speed_r;
    cs_n    = cruisespeed_r;
    case (state_r)
      ST_IDLE: begin
        if (throttle) begin
          state_n = ST_ACCEL;
          spd_n   = spd_up_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACCEL: begin
        if (set && throttle && engage_ok_s) begin
          state_n = ST_CRUISE;
          cs_n    = speed_r;
          spd_n   = spd_up_s;
        end else if (throttle) begin
          spd_n = spd_up_s;
        end else begin
          state_n = ST_DECEL;
          spd_n   = spd_coast_s;
        end
      end
      ST_DECEL: begin
        if (throttle) begin
          state_n = ST_ACCEL;
          spd_n   = spd_up_s;
        end else if (!zero_s) begin
          spd_n = spd_coast_s;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_CRUISE: begin
        if (brake) begin
          state_n = ST_BRAKE;
          spd_n   = spd_brk_s;
        end else if (cancel) begin
          state_n = ST_CANCEL;
          spd_n   = spd_coast_s;
        end else if (accel) begin
          cs_n  = cs_acc_s;
          spd_n = spd_acc_hold_s;
        end else if (coast) begin
          cs_n  = cs_coast_s;
          spd_n = spd_coast_hold_s;
        end else if (throttle) begin
          spd_n = spd_up_s;
        end else begin
          spd_n = spd_ramp_s;
        end
      end
      ST_BRAKE: begin
        if (zero_s && !resume) begin
          state_n = ST_IDLE;
        end else if (brake) begin
          spd_n = spd_brk_s;
        end else if (resume && engage_ok_s) begin
          state_n = ST_CRUISE;
        end else begin
          spd_n = spd_coast_s;
        end
      end
      ST_CANCEL: begin
        if (zero_s && !resume) begin
          state_n = ST_IDLE;
        end else if (resume && engage_ok_s && !brake) begin
          state_n = ST_CRUISE;
        end else if (brake) begin
          state_n = ST_BRAKE;
          spd_n   = spd_brk_s;
        end else begin
          spd_n = spd_coast_s;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      speed_r       <= {SPEED_W{1'b0}};
      cruisespeed_r <= {SPEED_W{1'b0}};
      cruisectrl_r  <= 1'b0;
      mode_r        <= HOLD_NONE;
    end else begin
      state_r       <= state_n;
      speed_r       <= spd_n;
      cruisespeed_r <= cs_n;
      cruisectrl_r  <= (state_n == ST_CRUISE);
      mode_r        <= mode_s;
    end
  end

endmodule

// File: tb/tb_cruise_ctrl_gen2.sv
// Directed bench for cruise_ctrl_gen2 with a behavioural reference model
// checked every cycle plus hand-computed literal expectations.
module tb_cruise_ctrl_gen2;
  import cruise_pkg::*;

  localparam int SW    = 8;
  localparam int MINE  = 46;
  localparam int MAXS  = 200;
  localparam int ACC   = 1;
  localparam int BRK   = 2;
  localparam int COAST = 2;
  localparam int RAMP  = 1;
  localparam int HOLD  = 4;

  localparam int S_IDLE   = int'(ST_IDLE);
  localparam int S_ACCEL  = int'(ST_ACCEL);
  localparam int S_DECEL  = int'(ST_DECEL);
  localparam int S_CRUISE = int'(ST_CRUISE);
  localparam int S_BRAKE  = int'(ST_BRAKE);
  localparam int S_CANCEL = int'(ST_CANCEL);

  localparam logic [7:0] M_T   = 8'h01;
  localparam logic [7:0] M_S   = 8'h02;
  localparam logic [7:0] M_A   = 8'h04;
  localparam logic [7:0] M_C   = 8'h08;
  localparam logic [7:0] M_X   = 8'h10;
  localparam logic [7:0] M_R   = 8'h20;
  localparam logic [7:0] M_B   = 8'h40;
  localparam logic [7:0] M_RST = 8'h80;
  localparam logic [7:0] M_0   = 8'h00;

  logic clk = 1'b0;
  logic reset = 1'b1, throttle = 1'b0, set = 1'b0, accel = 1'b0, coast = 1'b0;
  logic cancel = 1'b0, resume = 1'b0, brake = 1'b0;
  logic [SW-1:0] speed, cruisespeed;
  logic cruisectrl;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int m_st = 0, m_spd = 0, m_cs = 0, m_dir = 0, m_run = 0;
  int n_st, n_spd, n_cs, n_dir, n_run;

  cruise_ctrl_gen2 #(
    .SPEED_W(SW), .MIN_ENGAGE(MINE), .MAX_SPEED(MAXS), .ACC_STEP(ACC),
    .BRK_STEP(BRK), .COAST_STEP(COAST), .RAMP_STEP(RAMP), .HOLD_CYC(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .throttle(throttle), .set(set), .accel(accel),
    .coast(coast), .cancel(cancel), .resume(resume), .brake(brake),
    .speed(speed), .cruisespeed(cruisespeed), .cruisectrl(cruisectrl),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int up(input int v, input int d, input int ceil);
    return (v + d > ceil) ? ceil : v + d;
  endfunction

  function automatic int dn(input int v, input int d, input int fl);
    return (v - d < fl) ? fl : v - d;
  endfunction

  // Reference model: one cycle of the controller's rules on plain integers.
  task automatic model_step();
    int s, v, c, dir, run;
    bit tk;
    s = m_st; v = m_spd; c = m_cs; dir = 0; run = 0; tk = 1'b0;
    if (reset) begin
      s = S_IDLE; v = 0; c = 0;
    end else if (s == S_IDLE) begin
      if (throttle) begin s = S_ACCEL; v = up(v, ACC, MAXS); end
    end else if (s == S_ACCEL) begin
      if (set && throttle && v >= MINE) begin s = S_CRUISE; c = v; v = up(v, ACC, MAXS); end
      else if (throttle) v = up(v, ACC, MAXS);
      else begin s = S_DECEL; v = dn(v, COAST, 0); end
    end else if (s == S_DECEL) begin
      if (throttle) begin s = S_ACCEL; v = up(v, ACC, MAXS); end
      else if (v > 0) v = dn(v, COAST, 0);
      else s = S_IDLE;
    end else if (s == S_CRUISE) begin
      if (!brake && !cancel && (accel || coast)) begin
        dir = accel ? 1 : 2;
        run = (dir == m_dir) ? m_run + 1 : 1;
        tk  = ((run - 1) % HOLD) == 0;
      end
      if (brake) begin s = S_BRAKE; v = dn(v, BRK, 0); end
      else if (cancel) begin s = S_CANCEL; v = dn(v, COAST, 0); end
      else if (accel) begin
        if (tk) c = up(c, ACC, MAXS);
        v = up(v, ACC, MAXS);
        if (v > c) v = c;
      end else if (coast) begin
        if (tk) c = dn(c, COAST, MINE);
        v = dn(v, COAST, 0);
        if (v < c) v = c;
      end else if (throttle) v = up(v, ACC, MAXS);
      else if (v < c) v = up(v, RAMP, c);
      else if (v > c) v = dn(v, RAMP, c);
    end else begin
      // BRAKE or CANCEL
      if (v == 0 && !resume) s = S_IDLE;
      else if (s == S_BRAKE) begin
        if (brake) v = dn(v, BRK, 0);
        else if (resume && v >= MINE) s = S_CRUISE;
        else v = dn(v, COAST, 0);
      end else begin
        if (resume && v >= MINE && !brake) s = S_CRUISE;
        else if (brake) begin s = S_BRAKE; v = dn(v, BRK, 0); end
        else v = dn(v, COAST, 0);
      end
    end
    n_st = s; n_spd = v; n_cs = c; n_dir = dir; n_run = run;
  endtask

  task automatic cyc(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      throttle = m[0]; set = m[1]; accel = m[2]; coast = m[3];
      cancel = m[4]; resume = m[5]; brake = m[6]; reset = m[7];
      model_step();
      @(posedge clk);
      m_st = n_st; m_spd = n_spd; m_cs = n_cs; m_dir = n_dir; m_run = n_run;
      chk_en = 1'b1;
      #1;
    end
  endtask

  task automatic engage_at(input int tgt);
    cyc(M_RST, 1);
    cyc(M_T, tgt);
    cyc(M_T | M_S, 1);
    cyc(M_0, 1);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state_o", int'(state_o), m_st);
      check("speed", int'(speed), m_spd);
      check("cruisespeed", int'(cruisespeed), m_cs);
      check("cruisectrl", int'(cruisectrl), (m_st == S_CRUISE) ? 1 : 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and engage at 46
    cyc(M_RST, 2);
    check("rst_speed", int'(speed), 0);
    check("rst_cs", int'(cruisespeed), 0);
    check("rst_ctrl", int'(cruisectrl), 0);
    check("rst_state", int'(state_o), 0);
    cyc(M_T, 46);
    check("ramp46_speed", int'(speed), 46);
    cyc(M_T | M_S, 1);
    check("set_cs", int'(cruisespeed), 46);
    check("set_speed", int'(speed), 47);
    check("set_ctrl", int'(cruisectrl), 1);
    check("set_state", int'(state_o), S_CRUISE);
    cyc(M_0, 2);

    // Held accel from 50: target 51,52,53 at cycles 1,5,9
    engage_at(50);
    check("eng50_speed", int'(speed), 50);
    for (int i = 1; i <= 9; i++) begin
      cyc(M_A, 1);
      if (i == 1) check("acc1_cs", int'(cruisespeed), 51);
      if (i == 4) check("acc4_cs", int'(cruisespeed), 51);
      if (i == 5) check("acc5_cs", int'(cruisespeed), 52);
    end
    check("acc9_cs", int'(cruisespeed), 53);
    check("acc9_speed", int'(speed), 53);
    cyc(M_C, 5);
    cyc(M_A, 2);
    cyc(M_C, 1);
    cyc(M_A | M_C, 3);
    cyc(M_T, 3);
    cyc(M_0, 6);

    // Brake from 50, resume ignored below threshold, coast to IDLE
    engage_at(50);
    cyc(M_B, 3);
    check("brk_speed", int'(speed), 44);
    check("brk_ctrl", int'(cruisectrl), 0);
    check("brk_cs", int'(cruisespeed), 50);
    cyc(M_R, 1);
    check("res_low_state", int'(state_o), S_BRAKE);
    check("res_low_speed", int'(speed), 42);
    cyc(M_0, 22);
    check("brk_idle_state", int'(state_o), S_IDLE);
    check("brk_idle_cs", int'(cruisespeed), 50);

    // Saturation at MAX_SPEED (set below threshold ignored on the way up)
    cyc(M_RST, 1);
    cyc(M_T, 20);
    cyc(M_T | M_S, 1);
    cyc(M_T, 174);
    check("sat195_speed", int'(speed), 195);
    cyc(M_T, 10);
    check("sat_speed", int'(speed), 200);
    check("sat_state", int'(state_o), S_ACCEL);

    // DECEL from 1 with coast step 2 floors at 0 then IDLE
    cyc(M_RST, 1);
    cyc(M_T, 3);
    cyc(M_0, 1);
    check("dec1_state", int'(state_o), S_DECEL);
    check("dec1_speed", int'(speed), 1);
    cyc(M_0, 1);
    check("dec0_speed", int'(speed), 0);
    cyc(M_0, 1);
    check("dec_idle", int'(state_o), S_IDLE);

    // Cancel from 60, resume, ramp back to target
    engage_at(60);
    cyc(M_X, 2);
    check("can_speed", int'(speed), 56);
    check("can_state", int'(state_o), S_CANCEL);
    cyc(M_R, 1);
    check("can_res_state", int'(state_o), S_CRUISE);
    check("can_res_ctrl", int'(cruisectrl), 1);
    check("can_res_speed", int'(speed), 56);
    cyc(M_0, 4);
    check("ramp_speed", int'(speed), 60);
    cyc(M_B, 1);
    cyc(M_R, 1);
    cyc(M_0, 2);
    cyc(M_X, 1);
    cyc(M_B, 1);
    cyc(M_0, 2);

    // Reset mid-BRAKE overrides inputs; first free edge evaluates from IDLE
    engage_at(50);
    cyc(M_B, 2);
    cyc(M_RST | M_B | M_T, 1);
    check("mid_rst_speed", int'(speed), 0);
    check("mid_rst_cs", int'(cruisespeed), 0);
    check("mid_rst_ctrl", int'(cruisectrl), 0);
    check("mid_rst_state", int'(state_o), S_IDLE);
    cyc(M_T, 1);
    check("post_rst_state", int'(state_o), S_ACCEL);
    check("post_rst_speed", int'(speed), 1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
